// File: rtl/game_flow_ctrl.sv
// Game sequencer: turns PS/2 key events into screen transitions, gates the game
// core (reset/enable) and muxes renderer pixels onto VGA, swapping screens only at frame boundaries.
module game_flow_ctrl #(
  parameter int LOAD_FRAMES   = 30,
  parameter int RESULT_FRAMES = 180,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keydown,
  input  logic        ready,
  input  logic [8:0]  last_change,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        game_over,
  input  logic        game_win,
  input  logic [11:0] pix_title,
  input  logic [11:0] pix_help,
  input  logic [11:0] pix_game,
  input  logic [11:0] pix_result,
  output logic [11:0] pixel,
  output logic [2:0]  level,
  output logic [2:0]  screen,
  output logic        game_en,
  output logic        game_rst,
  output logic        result_win,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_TITLE  = 3'd0,
    ST_HELP   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_RESULT = 3'd5
  } state_t;

  localparam logic [8:0] KEY_1     = 9'h016;
  localparam logic [8:0] KEY_2     = 9'h01E;
  localparam logic [8:0] KEY_3     = 9'h026;
  localparam logic [8:0] KEY_QMARK = 9'h04A;
  localparam logic [8:0] KEY_ESC   = 9'h076;
  localparam logic [8:0] KEY_P     = 9'h04D;
  localparam logic [8:0] KEY_ENTER = 9'h05A;

  localparam logic [9:0] H_LIM       = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM       = 10'(V_ACTIVE);
  localparam logic [7:0] LOAD_LAST   = 8'(LOAD_FRAMES - 1);
  localparam logic [7:0] RESULT_LAST = 8'(RESULT_FRAMES - 1);

  state_t      state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [2:0]  screen_q, screen_d;
  logic [11:0] pixel_q, pixel_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        key_lock_q, key_lock_d;
  logic        game_en_q, game_en_d;
  logic        game_rst_q, game_rst_d;
  logic        result_win_q, result_win_d;

  logic        key_ev;
  logic        frame_tick;
  logic        in_active;
  logic [11:0] pix_src;

  // Key handshake: a key event is accepted in any cycle where keydown && ready
  // and the lock is clear; the lock then holds until keydown drops, so one press
  // gives one event no matter how often ready pulses while the key is held.
  always_comb begin
    key_ev     = keydown && ready && !key_lock_q;
    key_lock_d = keydown ? (key_lock_q || key_ev) : 1'b0;
    frame_tick = (h_cnt == 10'd0) && (v_cnt == V_LIM);
    in_active  = (h_cnt < H_LIM) && (v_cnt < V_LIM);
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    result_win_d = result_win_q;
    case (state_q)
      ST_TITLE: begin
        if (key_ev) begin
          case (last_change)
            KEY_1:     begin level_d = 3'd1; state_d = ST_LOAD; end
            KEY_2:     begin level_d = 3'd2; state_d = ST_LOAD; end
            KEY_3:     begin level_d = 3'd3; state_d = ST_LOAD; end
            KEY_QMARK: state_d = ST_HELP;
            default:   state_d = ST_TITLE;
          endcase
        end
      end
      ST_HELP: begin
        if (key_ev && last_change == KEY_ESC) state_d = ST_TITLE;
      end
      ST_LOAD: begin
        if (frame_tick && frame_cnt_q == LOAD_LAST) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Game outcome outranks any key arriving in the same cycle.
        if (game_win) begin
          state_d      = ST_RESULT;
          result_win_d = 1'b1;
        end else if (game_over) begin
          state_d      = ST_RESULT;
          result_win_d = 1'b0;
        end else if (key_ev && last_change == KEY_P) begin
          state_d = ST_PAUSE;
        end else if (key_ev && last_change == KEY_ESC) begin
          state_d = ST_TITLE;
          level_d = 3'd0;
        end
      end
      ST_PAUSE: begin
        if (key_ev && last_change == KEY_P) begin
          state_d = ST_PLAY;
        end else if (key_ev && last_change == KEY_ESC) begin
          state_d = ST_TITLE;
          level_d = 3'd0;
        end
      end
      ST_RESULT: begin
        if ((key_ev && last_change == KEY_ENTER) ||
            (frame_tick && frame_cnt_q == RESULT_LAST)) state_d = ST_TITLE;
      end
      default: state_d = ST_TITLE;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q && (state_d == ST_LOAD || state_d == ST_RESULT)) begin
      frame_cnt_d = 8'd0;
    end else if ((state_q == ST_LOAD || state_q == ST_RESULT) && frame_tick &&
                 frame_cnt_q != 8'hFF) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
    game_en_d  = (state_d == ST_PLAY);
    game_rst_d = (state_d == ST_TITLE) || (state_d == ST_HELP) || (state_d == ST_LOAD);
    // Screen lags the FSM so a frame never mixes two sources.
    screen_d   = frame_tick ? state_q : screen_q;
  end

  always_comb begin
    case (screen_q)
      3'd0:    pix_src = pix_title;
      3'd1:    pix_src = pix_help;
      3'd2:    pix_src = 12'h000;
      3'd3:    pix_src = pix_game;
      3'd4:    pix_src = {1'b0, pix_game[11:9], 1'b0, pix_game[7:5], 1'b0, pix_game[3:1]};
      3'd5:    pix_src = pix_result;
      default: pix_src = 12'h000;
    endcase
    pixel_d = in_active ? pix_src : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_TITLE;
      level_q      <= 3'd0;
      screen_q     <= 3'd0;
      pixel_q      <= 12'h000;
      frame_cnt_q  <= 8'd0;
      key_lock_q   <= 1'b0;
      game_en_q    <= 1'b0;
      game_rst_q   <= 1'b1;
      result_win_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      screen_q     <= screen_d;
      pixel_q      <= pixel_d;
      frame_cnt_q  <= frame_cnt_d;
      key_lock_q   <= key_lock_d;
      game_en_q    <= game_en_d;
      game_rst_q   <= game_rst_d;
      result_win_q <= result_win_d;
    end
  end

  assign pixel      = pixel_q;
  assign level      = level_q;
  assign screen     = screen_q;
  assign game_en    = game_en_q;
  assign game_rst   = game_rst_q;
  assign result_win = result_win_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a randomized run, all checked
// against a screen-level behavioural model of the sequencer.
module tb_game_flow_ctrl;

  localparam int LOAD_FRAMES   = 30;
  localparam int RESULT_FRAMES = 180;

  localparam logic [8:0] K1 = 9'h016, K2 = 9'h01E, K3 = 9'h026, KQ = 9'h04A;
  localparam logic [8:0] KESC = 9'h076, KP = 9'h04D, KENT = 9'h05A;

  logic        clk, rst, keydown, ready, game_over, game_win;
  logic [8:0]  last_change;
  logic [9:0]  h_cnt, v_cnt;
  logic [11:0] pix_title, pix_help, pix_game, pix_result;
  logic [11:0] pixel;
  logic [2:0]  level, screen, dbg_state;
  logic        game_en, game_rst, result_win;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_state, m_level, m_screen, m_frames;
  bit          m_lock, m_en, m_grst, m_win;
  logic [11:0] m_pixel;

  game_flow_ctrl dut (
    .clk(clk), .rst(rst), .keydown(keydown), .ready(ready), .last_change(last_change),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .game_over(game_over), .game_win(game_win),
    .pix_title(pix_title), .pix_help(pix_help), .pix_game(pix_game), .pix_result(pix_result),
    .pixel(pixel), .level(level), .screen(screen), .game_en(game_en), .game_rst(game_rst),
    .result_win(result_win), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_step();
    bit ev, tick, vis;
    int ns, nl;
    bit nw;
    logic [11:0] src;
    if (rst) begin
      m_state = 0; m_level = 0; m_screen = 0; m_frames = 0;
      m_lock = 0; m_en = 0; m_grst = 1; m_win = 0; m_pixel = 12'h000;
      return;
    end
    ev   = keydown && ready && !m_lock;
    tick = (h_cnt == 0) && (v_cnt == 480);
    vis  = (h_cnt < 640) && (v_cnt < 480);
    case (m_screen)
      0: src = pix_title;
      1: src = pix_help;
      2: src = 12'h000;
      3: src = pix_game;
      4: src = 12'((int'(pix_game[11:8]) / 2) * 256 + (int'(pix_game[7:4]) / 2) * 16
                   + int'(pix_game[3:0]) / 2);
      default: src = pix_result;
    endcase
    m_pixel = vis ? src : 12'h000;
    if (tick) m_screen = m_state;
    ns = m_state; nl = m_level; nw = m_win;
    case (m_state)
      0: if (ev) begin
           if (last_change == K1)      begin nl = 1; ns = 2; end
           else if (last_change == K2) begin nl = 2; ns = 2; end
           else if (last_change == K3) begin nl = 3; ns = 2; end
           else if (last_change == KQ) ns = 1;
         end
      1: if (ev && last_change == KESC) ns = 0;
      2: if (tick && m_frames + 1 >= LOAD_FRAMES) ns = 3;
      3: if (game_win) begin ns = 5; nw = 1; end
         else if (game_over) begin ns = 5; nw = 0; end
         else if (ev && last_change == KP) ns = 4;
         else if (ev && last_change == KESC) begin ns = 0; nl = 0; end
      4: if (ev && last_change == KP) ns = 3;
         else if (ev && last_change == KESC) begin ns = 0; nl = 0; end
      default: if ((ev && last_change == KENT) || (tick && m_frames + 1 >= RESULT_FRAMES)) ns = 0;
    endcase
    if (ns != m_state && (ns == 2 || ns == 5)) m_frames = 0;
    else if ((m_state == 2 || m_state == 5) && tick && m_frames < 255) m_frames++;
    m_lock  = keydown ? (m_lock || ev) : 1'b0;
    m_state = ns; m_level = nl; m_win = nw;
    m_en    = (ns == 3);
    m_grst  = (ns <= 2);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; keydown = 0; ready = 0; last_change = 9'h000;
    game_over = 0; game_win = 0;
    h_cnt = 10'($urandom_range(1, 639)); v_cnt = 10'($urandom_range(0, 479));
    pix_title = 12'($urandom); pix_help = 12'($urandom);
    pix_game = 12'($urandom); pix_result = 12'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  // one-cycle event, then release
  task automatic press(input logic [8:0] code);
    keydown = 1; ready = 1; last_change = code;
    cyc();
    keydown = 0; ready = 0;
  endtask

  task automatic boundary();
    h_cnt = 10'd0; v_cnt = 10'd480;
    cyc();
    h_cnt = 10'($urandom_range(1, 639)); v_cnt = 10'($urandom_range(0, 479));
    cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (pixel !== 12'h000) begin n_bad++; $display("FAIL reset_pixel got %h want 000", pixel); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (screen !== 3'd0) begin n_bad++; $display("FAIL reset_screen got %0d want 0", screen); end
    n_cmp++; if (game_en !== 1'b0 || game_rst !== 1'b1) begin
      n_bad++; $display("FAIL reset_game got en=%b rst=%b want en=0 rst=1", game_en, game_rst); end
    n_cmp++; if (result_win !== 1'b0 || dbg_state !== 3'd0) begin
      n_bad++; $display("FAIL reset_state got win=%b st=%0d want 0/0", result_win, dbg_state); end
  endtask

  task automatic test_load_entry();
    do_reset();
    h_cnt = 10'd200; v_cnt = 10'd100;
    press(K2);
    n_cmp++; if (level !== 3'd2 || dbg_state !== 3'd2 || game_rst !== 1'b1 || game_en !== 1'b0) begin
      n_bad++; $display("FAIL load_entry got lvl=%0d st=%0d rst=%b en=%b want 2/2/1/0",
                        level, dbg_state, game_rst, game_en); end
    n_cmp++; if (screen !== 3'd0) begin n_bad++; $display("FAIL load_screen_early got %0d want 0", screen); end
    for (int k = 1; k <= LOAD_FRAMES; k++) begin
      h_cnt = 10'd0; v_cnt = 10'd480;
      cyc();
      n_cmp++; if (dbg_state !== 3'((k < LOAD_FRAMES) ? 2 : 3)) begin
        n_bad++; $display("FAIL load_frames k=%0d got st=%0d want %0d", k, dbg_state, (k < LOAD_FRAMES) ? 2 : 3); end
      if (k == 1) begin
        n_cmp++; if (screen !== 3'd2) begin n_bad++; $display("FAIL load_screen got %0d want 2", screen); end
      end
      h_cnt = 10'd5; v_cnt = 10'd5;
      cyc();
    end
    n_cmp++; if (game_en !== 1'b1 || game_rst !== 1'b0) begin
      n_bad++; $display("FAIL play_enable got en=%b rst=%b want 1/0", game_en, game_rst); end
  endtask

  task automatic test_hold_key();
    do_reset();
    keydown = 1; last_change = K1;
    for (int i = 0; i < 100; i++) begin
      ready = 1;
      cyc();
      n_cmp++; if (level !== 3'(m_level) || dbg_state !== 3'(m_state)) begin
        n_bad++; $display("FAIL hold_key i=%0d got lvl=%0d st=%0d want %0d/%0d", i, level, dbg_state, m_level, m_state); end
    end
    keydown = 0; ready = 0; cyc();
    press(K3);
    n_cmp++; if (level !== 3'd1 || dbg_state !== 3'd2) begin
      n_bad++; $display("FAIL load_ignores_key got lvl=%0d st=%0d want 1/2", level, dbg_state); end
    repeat (LOAD_FRAMES) boundary();
    // a held P must toggle PLAY->PAUSE exactly once
    keydown = 1; last_change = KP;
    for (int i = 0; i < 50; i++) begin
      ready = 1'($urandom_range(0, 1)) | (i == 0);
      cyc();
      n_cmp++; if (dbg_state !== 3'd4 || dbg_state !== 3'(m_state)) begin
        n_bad++; $display("FAIL hold_p i=%0d got st=%0d want 4", i, dbg_state); end
    end
    keydown = 0; ready = 0; cyc();
  endtask

  task automatic test_priority();
    do_reset();
    press(K1);
    repeat (LOAD_FRAMES) boundary();
    game_over = 1; game_win = 1;
    press(KP);
    game_over = 0; game_win = 0;
    n_cmp++; if (dbg_state !== 3'd5 || result_win !== 1'b1 || game_en !== 1'b0) begin
      n_bad++; $display("FAIL win_priority got st=%0d win=%b en=%b want 5/1/0", dbg_state, result_win, game_en); end
    for (int k = 1; k <= RESULT_FRAMES; k++) begin
      boundary();
      if (k == RESULT_FRAMES - 1 || k == RESULT_FRAMES) begin
        n_cmp++; if (dbg_state !== 3'((k < RESULT_FRAMES) ? 5 : 0)) begin
          n_bad++; $display("FAIL result_timeout k=%0d got st=%0d want %0d", k, dbg_state, (k < RESULT_FRAMES) ? 5 : 0); end
      end
    end
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL result_level got %0d want 1", level); end
  endtask

  task automatic test_pause_dim();
    do_reset();
    press(K2);
    repeat (LOAD_FRAMES + 1) boundary();
    pix_game = 12'hFA6; h_cnt = 10'd10; v_cnt = 10'd10;
    cyc();
    n_cmp++; if (pixel !== 12'hFA6) begin n_bad++; $display("FAIL play_pixel got %h want FA6", pixel); end
    press(KP);
    n_cmp++; if (game_en !== 1'b0 || dbg_state !== 3'd4) begin
      n_bad++; $display("FAIL pause_en got en=%b st=%0d want 0/4", game_en, dbg_state); end
    cyc();
    n_cmp++; if (pixel !== 12'hFA6) begin n_bad++; $display("FAIL pause_pre_boundary got %h want FA6", pixel); end
    boundary(); h_cnt = 10'd300; v_cnt = 10'd300; cyc();
    n_cmp++; if (pixel !== 12'h753) begin n_bad++; $display("FAIL pause_dim got %h want 753", pixel); end
    press(KP);
    n_cmp++; if (game_en !== 1'b1) begin n_bad++; $display("FAIL resume_en got %b want 1", game_en); end
    boundary(); h_cnt = 10'd300; v_cnt = 10'd300; cyc();
    n_cmp++; if (pixel !== 12'hFA6) begin n_bad++; $display("FAIL resume_pixel got %h want FA6", pixel); end
    press(KESC);
    n_cmp++; if (dbg_state !== 3'd0 || level !== 3'd0) begin
      n_bad++; $display("FAIL esc_title got st=%0d lvl=%0d want 0/0", dbg_state, level); end
  endtask

  task automatic test_help_screen();
    do_reset();
    h_cnt = 10'd100; v_cnt = 10'd200;
    press(KQ);
    n_cmp++; if (dbg_state !== 3'd1 || screen !== 3'd0) begin
      n_bad++; $display("FAIL help_entry got st=%0d scr=%0d want 1/0", dbg_state, screen); end
    h_cnt = 10'd1; v_cnt = 10'd480; cyc();
    h_cnt = 10'd700; v_cnt = 10'd100; cyc();
    n_cmp++; if (screen !== 3'd0 || pixel !== 12'h000) begin
      n_bad++; $display("FAIL help_pre_boundary got scr=%0d pix=%h want 0/000", screen, pixel); end
    h_cnt = 10'd0; v_cnt = 10'd480; cyc();
    n_cmp++; if (screen !== 3'd1) begin n_bad++; $display("FAIL help_screen got %0d want 1", screen); end
    h_cnt = 10'd50; v_cnt = 10'd60; cyc();
    n_cmp++; if (pixel !== pix_help) begin n_bad++; $display("FAIL help_pixel got %h want %h", pixel, pix_help); end
    h_cnt = 10'd50; v_cnt = 10'd500; cyc();
    n_cmp++; if (pixel !== 12'h000) begin n_bad++; $display("FAIL vblank_pixel got %h want 000", pixel); end
    press(KESC);
    n_cmp++; if (dbg_state !== 3'd0 || screen !== 3'd1) begin
      n_bad++; $display("FAIL help_esc got st=%0d scr=%0d want 0/1", dbg_state, screen); end
    boundary();
    n_cmp++; if (screen !== 3'd0) begin n_bad++; $display("FAIL help_exit_screen got %0d want 0", screen); end
  endtask

  task automatic test_rst_mid_load();
    do_reset();
    press(K2);
    repeat (10) boundary();
    rst = 1; cyc(); rst = 0;
    n_cmp++; if (level !== 3'd0 || game_rst !== 1'b1 || game_en !== 1'b0 || screen !== 3'd0 ||
                 pixel !== 12'h000 || dbg_state !== 3'd0) begin
      n_bad++; $display("FAIL mid_reset got lvl=%0d rst=%b en=%b scr=%0d pix=%h st=%0d want 0/1/0/0/000/0",
                        level, game_rst, game_en, screen, pixel, dbg_state); end
    press(K3);
    for (int k = 1; k <= LOAD_FRAMES; k++) begin
      boundary();
      if (k >= LOAD_FRAMES - 1) begin
        n_cmp++; if (dbg_state !== 3'((k < LOAD_FRAMES) ? 2 : 3) || level !== 3'd3) begin
          n_bad++; $display("FAIL reload k=%0d got st=%0d lvl=%0d", k, dbg_state, level); end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] codes [8];
    codes = '{K1, K2, K3, KQ, KESC, KP, KENT, 9'h01C};
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 999) == 0);
      keydown     = 1'($urandom_range(0, 1));
      ready       = 1'($urandom_range(0, 1));
      last_change = codes[$urandom_range(0, 7)];
      game_over   = ($urandom_range(0, 60) == 0);
      game_win    = ($urandom_range(0, 80) == 0);
      if ($urandom_range(0, 3) == 0) begin
        h_cnt = 10'd0; v_cnt = 10'd480;
      end else begin
        h_cnt = 10'($urandom_range(0, 799)); v_cnt = 10'($urandom_range(0, 524));
      end
      pix_title = 12'($urandom); pix_help = 12'($urandom);
      pix_game = 12'($urandom); pix_result = 12'($urandom);
      cyc();
      n_cmp++; if (pixel !== m_pixel || screen !== 3'(m_screen)) begin
        n_bad++; $display("FAIL rnd_video i=%0d got pix=%h scr=%0d want %h/%0d", i, pixel, screen, m_pixel, m_screen); end
      n_cmp++; if (dbg_state !== 3'(m_state) || level !== 3'(m_level)) begin
        n_bad++; $display("FAIL rnd_fsm i=%0d got st=%0d lvl=%0d want %0d/%0d", i, dbg_state, level, m_state, m_level); end
      n_cmp++; if (game_en !== m_en || game_rst !== m_grst || result_win !== m_win) begin
        n_bad++; $display("FAIL rnd_ctrl i=%0d got en=%b rst=%b win=%b want %b/%b/%b",
                          i, game_en, game_rst, result_win, m_en, m_grst, m_win); end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_load_entry();
    test_hold_key();
    test_priority();
    test_pause_dim();
    test_help_screen();
    test_rst_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer that owns the VGA pixel path and the level register.
- Decodes PS/2 key events into screen transitions: title, help, load, play, pause, result.
- Holds the game core in reset, then enables it.
- Selects which renderer's pixel stream reaches the VGA output, switching screens only at a frame boundary so no frame shows two sources.
- Sits between the keyboard decoder, the VGA sync counters, the per-screen renderers and the game core.

## Interface
Parameters:
- LOAD_FRAMES, 30, frames game_rst is held in LOAD (1..255)
- RESULT_FRAMES, 180, frames RESULT is shown before auto-return to TITLE (1..255)
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame

Ports (reset is synchronous, active-high):
- clk  in  1  system clock, single domain
- rst  in  1  synchronous active-high reset
- keydown  in  1  key currently held (from keyboard decoder)
- ready  in  1  last_change valid this cycle
- last_change  in  9  scan code of most recent key
- h_cnt  in  10  VGA horizontal counter
- v_cnt  in  10  VGA vertical counter
- game_over  in  1  level lost (level-sensitive)
- game_win  in  1  level cleared (level-sensitive)
- pix_title, pix_help, pix_game, pix_result  in  12 each  renderer pixels, RGB444
- pixel  out  12  pixel to VGA DAC
- level  out  3  selected level 1..3; 0 = none
- screen  out  3  displayed screen code
- game_en  out  1  game core advance enable
- game_rst  out  1  game core reset
- result_win  out  1  result screen shows win (1) or loss (0)

## Operation
- State codes: TITLE=0, HELP=1, LOAD=2, PLAY=3, PAUSE=4, RESULT=5.
- Key event:
  - Asserted for one cycle when keydown && ready && !key_lock.
  - key_lock sets on that event and clears on the first cycle keydown=0.
  - A held key therefore yields exactly one event.
- Scan codes: KEY_1=0x016, KEY_2=0x01E, KEY_3=0x026, KEY_QMARK=0x04A, KEY_ESC=0x076, KEY_P=0x04D, KEY_ENTER=0x05A.
- Transitions take effect on the clock edge after the event:
  - TITLE: KEY_1/2/3 set level=1/2/3 and go to LOAD. KEY_QMARK goes to HELP. Other keys are ignored.
  - HELP: KEY_ESC goes to TITLE.
  - LOAD: all keys ignored. game_rst=1, game_en=0. Frame counter cleared on entry. After LOAD_FRAMES frame boundaries, go to PLAY.
  - PLAY: game_en=1, game_rst=0.
    - game_over goes to RESULT with result_win=0.
    - game_win goes to RESULT with result_win=1.
    - If both are high, game_win wins.
    - Otherwise KEY_P goes to PAUSE; KEY_ESC goes to TITLE with level=0.
  - PAUSE: game_en=0, game core state held. KEY_P goes to PLAY. KEY_ESC goes to TITLE with level=0.
  - RESULT: game_en=0. Frame counter cleared on entry. KEY_ENTER, or RESULT_FRAMES frame boundaries, goes to TITLE. level is retained.
- A game_over/game_win in the same cycle as a key event in PLAY has priority; the key is dropped.
- Frame boundary: the single cycle where h_cnt==0 && v_cnt==V_ACTIVE (start of vertical blank).
- Frame counter: 8 bits, saturates at 255, only counts in LOAD and RESULT.
- screen register:
  - Loads the FSM state only on a frame-boundary cycle.
  - A state change between boundaries is displayed from the next boundary.
  - Multiple changes between boundaries show only the latest.
- Pixel mux:
  - Source is chosen by screen: TITLE→pix_title, HELP→pix_help, LOAD→0x000, PLAY/PAUSE→pix_game, RESULT→pix_result.
  - Forced to 0x000 when h_cnt>=H_ACTIVE or v_cnt>=V_ACTIVE.
  - In PAUSE the output is pix_game with each 4-bit channel shifted right by 1 (dimmed).

## Timing
- All outputs registered.
- Reset values: pixel=0x000, level=0, screen=0 (TITLE), game_en=0, game_rst=1, result_win=0. FSM=TITLE, key_lock=0, frame counter=0.
- rst asserted mid-operation: on the next edge, all outputs and state take reset values regardless of the current state.
- Key event to FSM state / level / game_en / game_rst: 1 cycle.
- FSM state to screen: up to one frame (changes at next boundary edge).
- pixel latency: 1 cycle from h_cnt/v_cnt/pix_* inputs.
- LOAD duration: exactly LOAD_FRAMES boundaries after entry. game_rst drops on the same edge the FSM enters PLAY.

## Test plan
- Reset, then KEY_2 pulse (keydown=1, ready=1 for 1 cycle) → level=2, state LOAD, game_rst=1 next cycle. screen=2 after next boundary. PLAY and game_en=1 after 30 boundaries.
- Hold KEY_1 with ready pulsing every cycle for 100 cycles in TITLE → exactly one event: level=1, no re-trigger. Release and press again → event accepted (ignored in LOAD).
- PLAY, assert game_over and game_win together with a KEY_P event → RESULT, result_win=1, no PAUSE. Auto-return to TITLE after 180 boundaries.
- PLAY, KEY_P → game_en=0. pixel = pix_game 0xFA6 shown as 0x753 after next boundary. KEY_P again → game_en=1, pixel 0xFA6.
- KEY_QMARK at h_cnt=100, v_cnt=200 → screen stays 0 until h_cnt=0, v_cnt=480. Outside active area pixel=0x000. KEY_ESC returns screen to 0 at following boundary.
- rst pulsed during LOAD frame 10 → next cycle level=0, game_rst=1, game_en=0, screen=0, pixel=0x000. A later KEY_3 starts a full 30-frame LOAD.
